mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-ported memory between an instruction requester (port I)
//   and a data requester (port D).
//   Each transaction is granted exactly once, its command is registered, and it
//   is held on the memory port until mem_resp. The response is then routed back
//   to the granted requester.
//   Sits between the I/D caches (or the CPU) and the shared physical memory model.
// PARAMETERS
//   FIXED_D_PRIO  0   0: round-robin on simultaneous requests; 1: D always wins ties
//   TIMEOUT       0   max cycles waiting for mem_resp; 0 disables the watchdog
// PORTS
//   clk               in   1   single clock, rising edge
//   rst_n             in   1   asynchronous, active-low reset
//   i_read/i_write    in   1   port I request (held until i_resp)
//   i_byte_enable     in   4   port I byte enables
//   i_address         in   32  port I byte address
//   i_wdata           in   32  port I write data
//   i_resp            out  1   1-cycle completion pulse to port I
//   i_rdata           out  32  read data to port I, valid with i_resp
//   d_*               --   --  port D: same set and widths as port I
//   mem_read/mem_write out 1   registered command to memory
//   mem_byte_enable   out  4   registered byte enables
//   mem_address       out  32  registered address
//   mem_wdata         out  32  registered write data
//   mem_resp          in   1   memory completion, 1 cycle
//   mem_rdata         in   32  memory read data, valid with mem_resp
//   timeout_err       out  1   1-cycle pulse when the watchdog fires
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - state=IDLE; every mem_* output, *_resp and timeout_err = 0.
//     - last_grant=D, so the first tie goes to I.
//   States:
//     - IDLE -> BUSY_I or BUSY_D when a request is seen.
//     - BUSY_x -> IDLE on mem_resp or on timeout.
//   IDLE:
//     - Port x requests when x_read|x_write.
//     - One requester present: grant it.
//     - Both present: FIXED_D_PRIO=1 grants D; otherwise grant the port != last_grant.
//     - On grant at edge N, register read, write, byte_enable, address, wdata and
//       update last_grant; mem_* valid from cycle N+1.
//   BUSY_x:
//     - mem_* held constant from the register; requester inputs ignored.
//     - A requester deasserting mid-transaction does not abort it.
//     - On mem_resp=1 in cycle M: x_resp=1 and x_rdata=mem_rdata combinationally
//       in cycle M; the other port gets resp=0 and rdata=0.
//     - At edge M: mem_read/mem_write cleared, state=IDLE.
//   Arbitration timing:
//     - There is one dead IDLE cycle between transactions (M+1), so arbitration
//       sees fresh requests.
//     - A requester still asserting in M+1 because it sampled resp late is
//       re-granted; requesters must drop the request the cycle after resp.
//   Timing bounds: grant latency 1 cycle; back-to-back throughput is one
//     transaction per (mem latency + 2) cycles.
//   Read and write asserted together: forwarded unchanged; the memory defines
//     the result (illegal for requesters).
//   mem_resp while IDLE: ignored; no resp is generated.
//   Watchdog:
//     - Counter clears on grant and increments each BUSY cycle.
//     - When the counter reaches TIMEOUT with no mem_resp:
//       - timeout_err=1 for one cycle;
//       - granted x_resp=1 with rdata=0 so the requester is not deadlocked;
//       - state returns to IDLE.
//     - Counter width = $clog2(TIMEOUT+1).
//   Reset mid-BUSY: the transaction is abandoned immediately; no resp is issued.
// STRUCTURE
//   Package mem_arb_pkg:
//     - enum arb_state_t {IDLE, BUSY_I, BUSY_D};
//     - enum port_id_t {PORT_I, PORT_D};
//     - struct mem_cmd_t {read, write, byte_enable[3:0], address[31:0], wdata[31:0]}.
//   Sub-module arb_rr_pick: combinational 2-way picker
//     (req_i, req_d, last_grant, fixed_d) -> grant_valid, grant_id.
//   Top level: FSM, command register, and watchdog counter.
// TESTING
//   1 Lone I read of 0x100, mem resp after 3 cycles with 0xDEADBEEF:
//     - mem_read rises 1 cycle after i_read;
//     - i_resp=1 with i_rdata=0xDEADBEEF; d_resp stays 0.
//   2 Simultaneous I read 0x40 and D write 0x80 (be=4'b0011, wdata 0x1234),
//     FIXED_D_PRIO=0, from reset:
//     - I is served first, then D;
//     - mem_byte_enable=4'b0011, mem_wdata=0x1234 during the D transaction.
//   3 Both ports requesting continuously for 6 transactions:
//     - grants alternate I,D,I,D,I,D;
//     - with FIXED_D_PRIO=1, D wins every tie.
//   4 D drops d_write one cycle after its grant:
//     - mem_write stays 1 until mem_resp;
//     - d_resp pulses once; no second grant.
//   5 TIMEOUT=8, mem_resp never asserted:
//     - timeout_err pulses 8 cycles after grant with i_resp=1, i_rdata=0;
//     - next request is granted normally.
//   6 rst_n low for 1 cycle mid-BUSY_D:
//     - all outputs 0 asynchronously; no d_resp;
//     - the next tie grants I.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : mem_arb_pkg
// Brief  : Shared types for the I/D memory port arbiter
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_id_t;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [3:0]  byte_enable;
    logic [31:0] address;
    logic [31:0] wdata;
  } mem_cmd_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : arb_rr_pick
// Brief  : Combinational two-way picker (round-robin or fixed D priority)
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic     req_i,
  input  logic     req_d,
  input  port_id_t last_grant,
  input  logic     fixed_d,
  output logic     grant_valid,
  output port_id_t grant_id
);

  // A lone requester always wins; a tie goes to D when fixed, else away from the last winner
  always_comb begin
    grant_valid = req_i | req_d;
    grant_id    = PORT_I;
    if (req_i && req_d) begin
      if (fixed_d || (last_grant == PORT_I)) begin
        grant_id = PORT_D;
      end
    end else if (req_d) begin
      grant_id = PORT_D;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : mem_port_arbiter
// Brief  : Shares one single-ported memory between an I and a D requester
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter bit FIXED_D_PRIO = 1'b0,
  parameter int TIMEOUT      = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_read,
  input  logic        i_write,
  input  logic [3:0]  i_byte_enable,
  input  logic [31:0] i_address,
  input  logic [31:0] i_wdata,
  output logic        i_resp,
  output logic [31:0] i_rdata,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [3:0]  d_byte_enable,
  input  logic [31:0] d_address,
  input  logic [31:0] d_wdata,
  output logic        d_resp,
  output logic [31:0] d_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata,
  output logic        timeout_err
);

  // A zero-width counter is meaningless, so a disabled watchdog keeps one bit
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t state_q;
  port_id_t   last_grant_q;
  mem_cmd_t   cmd_q;
  mem_cmd_t   cmd_d;
  mem_cmd_t   i_cmd;
  mem_cmd_t   d_cmd;
  logic       grant_valid;
  port_id_t   grant_id;
  logic       busy;
  logic       wd_fire;
  logic       done;

  assign i_cmd = {i_read, i_write, i_byte_enable, i_address, i_wdata};
  assign d_cmd = {d_read, d_write, d_byte_enable, d_address, d_wdata};
  assign cmd_d = (grant_id == PORT_D) ? d_cmd : i_cmd;

  arb_rr_pick u_pick (
    .req_i       (i_read | i_write),
    .req_d       (d_read | d_write),
    .last_grant  (last_grant_q),
    .fixed_d     (FIXED_D_PRIO),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign busy = (state_q != IDLE);
  // A real memory response always beats the watchdog in the same cycle
  assign done = busy && (mem_resp || wd_fire);

  generate
    if (TIMEOUT > 0) begin : g_wdog
      logic [CNT_W-1:0] cnt_q;

      // Count BUSY cycles; held at zero while IDLE so every grant starts fresh
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else if (!busy) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      // Fires in the TIMEOUT-th BUSY cycle when memory stays silent
      assign wd_fire = busy && !mem_resp && ((cnt_q + 1'b1) == CNT_W'(TIMEOUT));
    end else begin : g_no_wdog
      assign wd_fire = 1'b0;
    end
  endgenerate

  // Arbitration FSM with the registered memory command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_D;
      cmd_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            state_q      <= (grant_id == PORT_D) ? BUSY_D : BUSY_I;
            last_grant_q <= grant_id;
            cmd_q        <= cmd_d;
          end
        end
        BUSY_I, BUSY_D: begin
          if (done) begin
            state_q       <= IDLE;
            cmd_q.read    <= 1'b0;
            cmd_q.write   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_read        = cmd_q.read;
  assign mem_write       = cmd_q.write;
  assign mem_byte_enable = cmd_q.byte_enable;
  assign mem_address     = cmd_q.address;
  assign mem_wdata       = cmd_q.wdata;

  // Completion is routed only to the owner; a watchdog completion returns zero data
  assign i_resp      = done && (state_q == BUSY_I);
  assign d_resp      = done && (state_q == BUSY_D);
  assign i_rdata     = ((state_q == BUSY_I) && mem_resp) ? mem_rdata : 32'h0;
  assign d_rdata     = ((state_q == BUSY_D) && mem_resp) ? mem_rdata : 32'h0;
  assign timeout_err = wd_fire;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_mem_port_arbiter
// Brief  : Scoreboard bench; instance 0 round-robin with watchdog 8,
//          instance 1 fixed D priority without watchdog
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    cmd_t cmd;
    int   cyc;
  } cmd_exp_t;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    bit          tmo;
    int          cyc;
  } rsp_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input int inst, input string nm, input logic [191:0] act, input logic [191:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL inst%0d %s: got %0h expected %0h (cycle %0d)", inst, nm, act, want, cyc);
    end
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    int   k;
    k       = $urandom_range(0, 9);
    c.rd    = (k < 5) || (k == 9);
    c.wr    = (k >= 5);
    c.be    = 4'($urandom);
    c.addr  = $urandom;
    c.wdata = $urandom;
    return c;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam bit FIXD = (g == 1);
    localparam int TMO  = (g == 0) ? 8 : 0;

    logic        rst_n;
    logic        i_read, i_write, i_resp;
    logic [3:0]  i_be;
    logic [31:0] i_addr, i_wdata, i_rdata;
    logic        d_read, d_write, d_resp;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_read, mem_write, mem_resp, timeout_err;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.FIXED_D_PRIO(FIXD), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_read(i_read), .i_write(i_write), .i_byte_enable(i_be), .i_address(i_addr),
      .i_wdata(i_wdata), .i_resp(i_resp), .i_rdata(i_rdata),
      .d_read(d_read), .d_write(d_write), .d_byte_enable(d_be), .d_address(d_addr),
      .d_wdata(d_wdata), .d_resp(d_resp), .d_rdata(d_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_be),
      .mem_address(mem_addr), .mem_wdata(mem_wdata), .mem_resp(mem_resp),
      .mem_rdata(mem_rdata), .timeout_err(timeout_err)
    );

    // Reference model state: one outstanding transaction per port, index 0=I 1=D
    cmd_t     pend [2];
    bit       pend_v [2];
    bit       blocked [2];
    bit       busy;
    int       owner;
    int       last;
    int       kcnt;
    int       lat;
    bit       done = 1'b0;
    cmd_exp_t cmd_q [$];
    rsp_exp_t rsp_q [$];

    task automatic drive_port(input int p, input bit en, input cmd_t c);
      cmd_t v;
      v = c;
      if (!en) begin
        v.rd = 1'b0;
        v.wr = 1'b0;
      end
      if (p == 0) {i_read, i_write, i_be, i_addr, i_wdata} = v;
      else        {d_read, d_write, d_be, d_addr, d_wdata} = v;
    endtask

    task automatic finish_txn();
      busy           = 1'b0;
      pend_v[owner]  = 1'b0;
      blocked[owner] = 1'b1;
    endtask

    // One clock cycle of requesters + memory; called just after the rising edge
    task automatic step(input int p_new, input bit stall);
      int w;
      for (int p = 0; p < 2; p++) begin
        if (!pend_v[p] && !blocked[p] && ($urandom_range(0, 99) < p_new)) begin
          pend[p]   = rand_cmd();
          pend_v[p] = 1'b1;
        end
        blocked[p] = 1'b0;
        if (busy && (p == owner)) drive_port(p, $urandom_range(0, 1) == 1, rand_cmd());
        else                      drive_port(p, pend_v[p], pend[p]);
      end
      mem_resp  = 1'b0;
      mem_rdata = $urandom;
      if (!busy) begin
        if ($urandom_range(0, 3) == 0) mem_resp = 1'b1;
        if (pend_v[0] || pend_v[1]) begin
          if (pend_v[0] && pend_v[1]) w = FIXD ? 1 : 1 - last;
          else                        w = pend_v[1] ? 1 : 0;
          busy  = 1'b1;
          owner = w;
          last  = w;
          kcnt  = 0;
          lat   = stall ? 1000 : $urandom_range(1, 8);
          cmd_q.push_back('{pend[w], cyc + 1});
        end
      end else begin
        kcnt++;
        if (kcnt == lat) begin
          mem_resp = 1'b1;
          rsp_q.push_back('{owner, mem_rdata, 1'b0, cyc});
          finish_txn();
        end else if ((TMO > 0) && (kcnt == TMO)) begin
          rsp_q.push_back('{owner, 32'h0, 1'b1, cyc});
          finish_txn();
        end
      end
    endtask

    task automatic run(input int n, input int p_new, input bit stall);
      repeat (n) begin
        @(posedge clk);
        #1 step(p_new, stall);
      end
    endtask

    task automatic drain(input string nm);
      int guard;
      guard = 0;
      while ((busy || pend_v[0] || pend_v[1]) && (guard < 300)) begin
        run(1, 0, 1'b0);
        guard++;
      end
      run(3, 0, 1'b0);
      chk(g, {nm, "_cmd_left"}, cmd_q.size(), 0);
      chk(g, {nm, "_resp_left"}, rsp_q.size(), 0);
    endtask

    task automatic check_quiet(input string nm);
      chk(g, nm, {mem_read, mem_write, mem_be, mem_addr, mem_wdata,
                  i_resp, d_resp, timeout_err, i_rdata, d_rdata}, '0);
    endtask

    task automatic model_reset();
      busy       = 1'b0;
      last       = 1;
      pend_v[0]  = 1'b0;
      pend_v[1]  = 1'b0;
      blocked[0] = 1'b0;
      blocked[1] = 1'b0;
      drive_port(0, 1'b0, '0);
      drive_port(1, 1'b0, '0);
    endtask

    // Stimulus driver
    initial begin
      rst_n     = 1'b0;
      mem_resp  = 1'b0;
      mem_rdata = 32'h0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 mem_resp = 1'b1;
      mem_rdata = $urandom;
      #1 check_quiet("reset_state");
      mem_resp = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      // first tie out of reset
      pend[0] = rand_cmd(); pend[1] = rand_cmd();
      pend_v[0] = 1'b1; pend_v[1] = 1'b1;
      run(400, 40, 1'b0);
      run(60, 100, 1'b0);
      drain("random");
      if (TMO > 0) begin
        run(30, 60, 1'b1);
        drain("watchdog");
        run(30, 50, 1'b0);
      end
      drain("pre_reset");
      // park a transaction on a silent memory, then reset mid-BUSY
      while (!busy) run(1, 100, 1'b1);
      run(2, 0, 1'b1);
      #2 rst_n = 1'b0;
      #1 check_quiet("async_reset");
      model_reset();
      mem_resp  = 1'b1;
      mem_rdata = $urandom;
      cmd_q.delete();
      rsp_q.delete();
      @(posedge clk);
      #1 check_quiet("held_reset");
      #2 rst_n  = 1'b1;
      mem_resp = 1'b0;
      pend[0] = rand_cmd(); pend[1] = rand_cmd();
      pend_v[0] = 1'b1; pend_v[1] = 1'b1;
      run(80, 40, 1'b0);
      drain("final");
      done = 1'b1;
    end

    // Monitor: compares every memory command and every completion against the queues
    initial begin
      cmd_t     cur;
      cmd_t     held;
      bit       prev_act;
      cmd_exp_t ce;
      rsp_exp_t re;
      prev_act = 1'b0;
      held     = '0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          prev_act = 1'b0;
        end else begin
          cur = {mem_read, mem_write, mem_be, mem_addr, mem_wdata};
          if ((mem_read | mem_write) && !prev_act) begin
            if (cmd_q.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL inst%0d unexpected_cmd: got %0h expected none (cycle %0d)", g, cur, cyc);
            end else begin
              ce = cmd_q.pop_front();
              chk(g, "mem_cmd", cur, ce.cmd);
              chk(g, "mem_cmd_cycle", cyc, ce.cyc);
            end
            held = cur;
          end else if (mem_read | mem_write) begin
            chk(g, "mem_cmd_hold", cur, held);
          end
          prev_act = mem_read | mem_write;
          if (i_resp | d_resp | timeout_err) begin
            if (rsp_q.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL inst%0d unexpected_resp: got i=%0b d=%0b tmo=%0b expected none (cycle %0d)",
                       g, i_resp, d_resp, timeout_err, cyc);
            end else begin
              re = rsp_q.pop_front();
              chk(g, "resp_port", {i_resp, d_resp}, (re.port == 0) ? 2'b10 : 2'b01);
              chk(g, "resp_rdata", (re.port == 0) ? i_rdata : d_rdata, re.rdata);
              chk(g, "other_rdata", (re.port == 0) ? d_rdata : i_rdata, 32'h0);
              chk(g, "timeout_err", timeout_err, re.tmo);
              chk(g, "resp_cycle", cyc, re.cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    int budget;
    budget = 0;
    while (!(g_inst[0].done && g_inst[1].done) && (budget < 20000)) begin
      @(posedge clk);
      budget++;
    end
    if (!(g_inst[0].done && g_inst[1].done)) begin
      n_checks++;
      n_errors++;
      $display("FAIL run_budget: got done=%0b%0b expected 11", g_inst[0].done, g_inst[1].done);
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
